// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: instruction geometry, decode field
// positions, the NOP encoding and the fetch step.
package mips_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned FIELD_W    = 6;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned PC_STEP    = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {instr, pc} pair.
//   clk, rst_n         clock, async active-low reset
//   push/pushInstr/
//   pushPc             load a new entry (wins over pop when both set)
//   pop                release the held entry
//   flush              drop the held entry (wins over everything)
//   full, instr, pc    registered entry state
module if_skid_buf
  import mips_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] pushInstr,
  input  logic [AW-1:0] pushPc,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc
);

  logic          fullD;
  logic [DW-1:0] instrD;
  logic [AW-1:0] pcD;

  // Next-state: flush dominates, a push refills even while popping.
  always_comb begin
    fullD  = full;
    instrD = instr;
    pcD    = pc;
    if (flush) begin
      fullD = 1'b0;
    end else if (push) begin
      fullD  = 1'b1;
      instrD = pushInstr;
      pcD    = pushPc;
    end else if (pop) begin
      fullD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else begin
      full  <= fullD;
      instr <= instrD;
      pc    <= pcD;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, buffers up to two words (out register + skid) and
// hands them to decode over valid/ready. Redirects flush wrong-path state.
//   clk, rst_n            clock, async active-low reset
//   imem_req, imem_addr   read strobe / word address to instruction memory
//   imem_rdata            read data, valid the cycle after imem_req
//   redirect_valid/_pc    branch/jump redirect, highest priority
//   id_valid, id_ready    decode handshake
//   id_instr, id_pc       registered instruction and its address
//   id_opcode, id_funct   pre-sliced decode fields of id_instr
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned    AW       = ADDR_W,
  parameter int unsigned    DW       = INSTR_W,
  parameter logic [AW-1:0]  RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic [DW-1:0]      imem_rdata,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [DW-1:0]      id_instr,
  output logic [AW-1:0]      id_pc,
  output logic [FIELD_W-1:0] id_opcode,
  output logic [FIELD_W-1:0] id_funct
);

  logic [AW-1:0] pcQ, pcD;
  logic [AW-1:0] reqPcQ, reqPcD;
  logic          pendingQ, pendingD;
  logic          outValidQ, outValidD;
  logic [DW-1:0] outInstrQ, outInstrD;
  logic [AW-1:0] outPcQ, outPcD;

  logic          skidFull;
  logic [DW-1:0] skidInstr;
  logic [AW-1:0] skidPc;
  logic          skidPush, skidPop, skidFlush;

  logic          fire;
  logic          redirectLive;
  logic [1:0]    heldSum;
  logic [1:0]    occ;
  logic [AW-1:0] redirectAddr;

  if_skid_buf #(.AW(AW), .DW(DW)) uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (skidPush),
    .pushInstr(imem_rdata),
    .pushPc   (reqPcQ),
    .pop      (skidPop),
    .flush    (skidFlush),
    .full     (skidFull),
    .instr    (skidInstr),
    .pc       (skidPc)
  );

  // Issue logic. Reads are suppressed while in reset so the strobe reads 0
  // there; after release the first read goes out in the very next cycle.
  always_comb begin
    fire         = outValidQ && id_ready;
    redirectLive = rst_n && redirect_valid;
    redirectAddr = {redirect_pc[AW-1:2], 2'b00};
    heldSum      = 2'(outValidQ) + 2'(skidFull) + 2'(pendingQ);
    occ          = heldSum - 2'(fire);
    imem_req     = rst_n && ((occ < 2'd2) || redirect_valid);
    imem_addr    = redirectLive ? redirectAddr : pcQ;
  end

  // Next-state for PC, pending read and output register; routes responses.
  always_comb begin
    pcD       = pcQ;
    reqPcD    = imem_req ? imem_addr : reqPcQ;
    pendingD  = imem_req;
    outValidD = outValidQ;
    outInstrD = outInstrQ;
    outPcD    = outPcQ;
    skidPush  = 1'b0;
    skidPop   = 1'b0;
    skidFlush = 1'b0;

    if (redirect_valid) begin
      // Everything buffered or returning this cycle is wrong-path.
      pcD       = redirectAddr + AW'(PC_STEP);
      outValidD = 1'b0;
      outInstrD = DW'(NOP_INSTR);
      outPcD    = '0;
      skidFlush = 1'b1;
    end else begin
      if (imem_req) begin
        pcD = pcQ + AW'(PC_STEP);
      end
      if (outValidQ && !fire) begin
        // Out is held; a returning word can only go to the skid.
        skidPush = pendingQ;
      end else if (skidFull) begin
        // Skid is older than any arriving word, so it drains first.
        outValidD = 1'b1;
        outInstrD = skidInstr;
        outPcD    = skidPc;
        skidPop   = 1'b1;
        skidPush  = pendingQ;
      end else if (pendingQ) begin
        outValidD = 1'b1;
        outInstrD = imem_rdata;
        outPcD    = reqPcQ;
      end else begin
        outValidD = 1'b0;
        outInstrD = DW'(NOP_INSTR);
        outPcD    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ       <= RESET_PC;
      reqPcQ    <= RESET_PC;
      pendingQ  <= 1'b0;
      outValidQ <= 1'b0;
      outInstrQ <= DW'(NOP_INSTR);
      outPcQ    <= '0;
    end else begin
      pcQ       <= pcD;
      reqPcQ    <= reqPcD;
      pendingQ  <= pendingD;
      outValidQ <= outValidD;
      outInstrQ <= outInstrD;
      outPcQ    <= outPcD;
    end
  end

  assign id_valid  = outValidQ;
  assign id_instr  = outInstrQ;
  assign id_pc     = outPcQ;
  assign id_opcode = outInstrQ[OPCODE_MSB:OPCODE_LSB];
  assign id_funct  = outInstrQ[FUNCT_MSB:FUNCT_LSB];

  // The issue rule keeps held + in-flight words within the two slots.
  assert property (@(posedge clk) disable iff (!rst_n) heldSum <= 2'd2);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;

  // Second instance exercising the address wrap from a high reset PC.
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2 = 32'h0;
  logic        redir2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [5:0]  op2;
  logic [5:0]  fn2;

  int tests = 0;
  int fails = 0;
  bit monEn = 1'b0;
  bit wrapDone = 1'b0;

  logic [31:0] expQ[$];
  logic [31:0] lastPushed = 32'h0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct(id_funct)
  );

  if_fetch_stage #(.RESET_PC(WRAP_PC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .redirect_valid(redir2), .redirect_pc(rpc2),
    .id_valid(valid2), .id_ready(ready2), .id_instr(instr2), .id_pc(pc2),
    .id_opcode(op2), .id_funct(fn2)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0109_5020;
    if (a == 32'h0000_0204) return 32'h8D09_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? memWord(imem_addr) : 32'hDEAD_BEEF;
    rdata2     <= req2 ? memWord(addr2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: program-order address stream from the latest start point.
  task automatic restartExp(input logic [31:0] pc);
    expQ.delete();
    expQ.push_back(pc);
    lastPushed = pc;
  endtask

  always @(posedge clk) begin
    while (expQ.size() < 8) begin
      lastPushed = lastPushed + 32'd4;
      expQ.push_back(lastPushed);
    end
  end

  // Monitor / scoreboard: compares every completed transfer and stall hold.
  bit          prevHold = 1'b0;
  logic [31:0] prevPc, prevInstr;
  always @(negedge clk) begin
    logic [31:0] e, w;
    if (!rst_n || !monEn) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        chk("hold_pc", id_valid && id_pc == prevPc, id_pc, prevPc);
        chk("hold_instr", id_instr == prevInstr, id_instr, prevInstr);
      end
      if (!id_valid) begin
        chk("empty_nop", id_instr == 32'h0 && id_pc == 32'h0, id_instr | id_pc, 32'h0);
      end else if (id_ready && !redirect_valid) begin
        if (expQ.size() == 0) begin
          chk("sb_underflow", 1'b0, id_pc, 32'h0);
        end else begin
          e = expQ.pop_front();
          w = memWord(e);
          chk("xfer_pc", id_pc == e, id_pc, e);
          chk("xfer_instr", id_instr == w, id_instr, w);
          chk("xfer_opcode", id_opcode == w[31:26], 32'(id_opcode), 32'(w[31:26]));
          chk("xfer_funct", id_funct == w[5:0], 32'(id_funct), 32'(w[5:0]));
          if (e == 32'h200) begin
            chk("add_opcode", id_opcode == 6'h00, 32'(id_opcode), 32'h00);
            chk("add_funct", id_funct == 6'h20, 32'(id_funct), 32'h20);
          end
          if (e == 32'h204)
            chk("lw_opcode", id_opcode == 6'h23, 32'(id_opcode), 32'h23);
        end
      end
      prevHold  = id_valid && !id_ready && !redirect_valid;
      prevPc    = id_pc;
      prevInstr = id_instr;
    end
  end

  // Wrap check on the high-reset-PC instance after the first reset release.
  initial begin : wrapChk
    logic [31:0] expPc [3];
    int got;
    expPc[0] = 32'hFFFF_FFF8;
    expPc[1] = 32'hFFFF_FFFC;
    expPc[2] = 32'h0000_0000;
    got = 0;
    wait (rst_n === 1'b1);
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (valid2) begin
        chk("wrap_pc", pc2 == expPc[got], pc2, expPc[got]);
        chk("wrap_instr", instr2 == memWord(expPc[got]), instr2, memWord(expPc[got]));
        got++;
      end
    end
    if (got < 3) chk("wrap_timeout", 1'b0, 32'(got), 32'd3);
    wrapDone = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_req"}, imem_req == 1'b0, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, imem_addr == RST_PC, imem_addr, RST_PC);
    chk({tag, "_valid"}, id_valid == 1'b0, 32'(id_valid), 32'h0);
    chk({tag, "_instr"}, id_instr == 32'h0, id_instr, 32'h0);
    chk({tag, "_pc"}, id_pc == 32'h0, id_pc, 32'h0);
    chk({tag, "_fields"}, id_opcode == 6'h0 && id_funct == 6'h0,
        32'({id_opcode, id_funct}), 32'h0);
  endtask

  task automatic doRedirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    restartExp({tgt[31:2], 2'b00});
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin : stim
    int reqCnt;
    logic lastReq;
    logic [31:0] tgt;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");

    // Reset release and streaming start-up.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    restartExp(RST_PC);
    monEn = 1'b1;
    #1;
    chk("first_req", imem_req == 1'b1, 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr == RST_PC, imem_addr, RST_PC);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("stream_req", imem_req == 1'b1, 32'(imem_req), 32'h1);
      chk("stream_addr", imem_addr == 32'(4 * k), imem_addr, 32'(4 * k));
      if (k == 1) chk("lat_not_yet", id_valid == 1'b0, 32'(id_valid), 32'h0);
      if (k == 2) chk("lat_first", id_valid && id_pc == RST_PC, id_pc, RST_PC);
      if (k >= 2) chk("throughput", id_valid == 1'b1, 32'(id_valid), 32'h1);
    end
    tick();
    repeat (4) tick();

    // Stall for five cycles, then release.
    id_ready = 1'b0;
    reqCnt = 0;
    lastReq = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      reqCnt += int'(imem_req);
      lastReq = imem_req;
      tick();
    end
    chk("stall_issues", reqCnt <= 2, 32'(reqCnt), 32'd2);
    chk("stall_req_low", lastReq == 1'b0, 32'(lastReq), 32'h0);
    id_ready = 1'b1;
    repeat (10) tick();

    // Redirect while the buffers are full.
    id_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    restartExp(32'h0000_0100);
    @(negedge clk);
    chk("redir_req", imem_req == 1'b1, 32'(imem_req), 32'h1);
    chk("redir_addr", imem_addr == 32'h100, imem_addr, 32'h100);
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("redir_gap", id_valid == 1'b0, 32'(id_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("redir_target", id_valid && id_pc == 32'h100, id_pc, 32'h100);
    tick();
    repeat (4) tick();

    // Decode fields, then back-to-back redirects (last one wins).
    doRedirect(32'h0000_0200);
    repeat (6) tick();
    doRedirect(32'h0000_0300);
    doRedirect(32'h0000_0402);
    repeat (6) tick();

    // Async reset with a read in flight; stale response must be ignored.
    monEn = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid");
    #1;
    rst_n = 1'b1;
    restartExp(RST_PC);
    monEn = 1'b1;
    @(negedge clk);
    chk("rst_gap0", id_valid == 1'b0, 32'(id_valid), 32'h0);
    @(negedge clk);
    chk("rst_gap1", id_valid == 1'b0, 32'(id_valid), 32'h0);
    @(negedge clk);
    chk("rst_first", id_valid && id_pc == RST_PC, id_pc, RST_PC);
    tick();

    // Randomized backpressure and redirects.
    for (int c = 0; c < 2000; c++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        restartExp({tgt[31:2], 2'b00});
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    repeat (5) tick();

    for (int c = 0; c < 50 && !wrapDone; c++) tick();
    if (!wrapDone) chk("wrap_done", 1'b0, 32'h0, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
